// File: rtl/width_converter.sv
// ADC capture buffer: fills a frame of 16-bit samples, then
// drains it as a gap-free 8-bit byte stream, high byte first.
module width_converter #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int RST_BUSY_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] din_i,
  output logic        wr_en_o,
  output logic [7:0]  dout_o,
  output logic        eth_en_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        rst_busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 2;
  localparam int BW = (RST_BUSY_CYCLES < 1) ? 1
                    : $clog2(RST_BUSY_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(2 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_WAIT
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rstate_t;

  wstate_t wst_q, wst_d;
  rstate_t rst_q, rst_d;

  logic [BW-1:0] busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    dout_q, dout_d;
  logic          eth_q;
  logic [15:0]   mem_q [DEPTH_WORDS];

  logic rst_busy;
  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic push;
  logic pop;
  logic [15:0] rd_word;

  assign rst_busy = rst_i | (busy_q != '0);
  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign rd_word  = mem_q[rd_ptr_q[AW:1]];

  // Writes need room for both bytes; reads need a byte present.
  assign push = wr_en && (cnt_q <= CNT_FULL - CW'(2));
  assign pop  = rd_en && !empty;

  always_comb begin
    wst_d = wst_q;
    wr_en = 1'b0;
    unique case (wst_q)
      W_IDLE: if (start_i && !rst_busy) wst_d = W_FILL;
      W_FILL: begin
        if (full) wst_d = W_WAIT;
        else      wr_en = !rst_busy;
      end
      W_WAIT: if (empty) wst_d = start_i ? W_FILL : W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d = rst_q;
    rd_en = 1'b0;
    unique case (rst_q)
      R_IDLE: if (full && !rst_busy) rst_d = R_DRAIN;
      R_DRAIN: begin
        if (empty) rst_d = R_IDLE;
        else       rd_en = !rst_busy;
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (busy_q != '0) busy_d = busy_q - BW'(1);
    if (push) begin
      cnt_d    = cnt_d + CW'(2);
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      cnt_d    = cnt_d - CW'(1);
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      dout_d   = rd_ptr_q[0] ? rd_word[7:0] : rd_word[15:8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wst_q    <= W_IDLE;
      rst_q    <= R_IDLE;
      busy_q   <= BW'(RST_BUSY_CYCLES);
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      eth_q    <= 1'b0;
    end else begin
      wst_q    <= wst_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      eth_q    <= rd_en;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= din_i;
  end

  assign wr_en_o    = wr_en;
  assign dout_o     = dout_q;
  assign eth_en_o   = eth_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign rst_busy_o = rst_busy;

endmodule

// File: tb/tb_width_converter.sv
// Bench for width_converter: reset/first-frame vector table,
// directed corner sequences and a random run against a byte scoreboard.
module tb_width_converter;

  localparam int DW = 4;
  localparam int RB = 2;
  localparam int FB = 2 * DW;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic        wr_en;
  logic [7:0]  dout;
  logic        eth_en;
  logic        full;
  logic        empty;
  logic        rst_busy;

  always #5 clk = ~clk;

  width_converter #(
    .DEPTH_WORDS    (DW),
    .RST_BUSY_CYCLES(RB)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .din_i     (din),
    .wr_en_o   (wr_en),
    .dout_o    (dout),
    .eth_en_o  (eth_en),
    .full_o    (full),
    .empty_o   (empty),
    .rst_busy_o(rst_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Reference model: bytes a frame should deliver, in order.
  logic [7:0]  expq[$];
  logic        mon_en    = 1'b0;
  logic        wr_prev   = 1'b0;
  logic        rst_prev  = 1'b1;
  logic        eth_prev  = 1'b0;
  logic [15:0] din_prev  = '0;
  logic [7:0]  last_dout = '0;
  int          since     = 0;
  int          eth_run   = 0;
  int          wr_run    = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_prev) begin
        expq.delete();
        since   = 1;
        eth_run = 0;
        wr_run  = 0;
      end else begin
        if (since < 1000) since++;
        if (wr_prev) begin
          expq.push_back(din_prev[15:8]);
          expq.push_back(din_prev[7:0]);
        end
      end
      chk("rst_busy", rst_busy, (rst || since <= RB));
      if (rst_prev) begin
        chk("eth_after_rst", eth_en, 0);
        chk("dout_after_rst", dout, 0);
      end else if (eth_en) begin
        if (expq.size() == 0) chk("byte_expected", eth_en, 0);
        else chk("dout_stream", dout, expq.pop_front());
      end else begin
        chk("dout_hold", dout, last_dout);
      end
      last_dout = dout;
      chk("full", full, (expq.size() == FB));
      chk("empty", empty, (expq.size() == 0));
      if (rst_busy) chk("wr_in_busy", wr_en, 0);
      if (wr_en) chk("wr_while_drain", eth_en, 0);
      if (eth_en) eth_run++;
      else begin
        if (eth_prev && !rst_prev) chk("eth_burst", eth_run, FB);
        eth_run = 0;
      end
      if (wr_en) wr_run++;
      else begin
        if (wr_prev && !rst) chk("wr_burst", wr_run, DW);
        wr_run = 0;
      end
      wr_prev  = wr_en;
      din_prev = din;
      rst_prev = rst;
      eth_prev = eth_en;
    end
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic        wr;
    logic        eth;
    logic [7:0]  dout;
    logic        full;
    logic        empty;
    logic        busy;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic r, logic s, logic [15:0] d,
                              logic w, logic e, logic [7:0] o,
                              logic f, logic m, logic b);
    vec_t v;
    v.rst = r; v.start = s; v.din = d; v.wr = w; v.eth = e;
    v.dout = o; v.full = f; v.empty = m; v.busy = b;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    tbl[0]  = mk(1, 0, 16'hFFFF, 0, 0, 8'h00, 0, 1, 1);
    tbl[1]  = mk(0, 1, 16'hFFFF, 0, 0, 8'h00, 0, 1, 1);
    tbl[2]  = mk(0, 1, 16'hFFFF, 0, 0, 8'h00, 0, 1, 1);
    tbl[3]  = mk(0, 1, 16'hFFFF, 0, 0, 8'h00, 0, 1, 0);
    tbl[4]  = mk(0, 1, 16'h0000, 1, 0, 8'h00, 0, 1, 0);
    tbl[5]  = mk(0, 1, 16'h0001, 1, 0, 8'h00, 0, 0, 0);
    tbl[6]  = mk(0, 1, 16'h0002, 1, 0, 8'h00, 0, 0, 0);
    tbl[7]  = mk(0, 1, 16'h0003, 1, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mk(0, 0, 16'hFFFF, 0, 0, 8'h00, 1, 0, 0);
    tbl[9]  = mk(0, 0, 16'hFFFF, 0, 0, 8'h00, 1, 0, 0);
    tbl[10] = mk(0, 0, 16'hFFFF, 0, 1, 8'h00, 0, 0, 0);
    tbl[11] = mk(0, 0, 16'hFFFF, 0, 1, 8'h00, 0, 0, 0);
    tbl[12] = mk(0, 0, 16'hFFFF, 0, 1, 8'h00, 0, 0, 0);
    tbl[13] = mk(0, 0, 16'hFFFF, 0, 1, 8'h01, 0, 0, 0);
    tbl[14] = mk(0, 0, 16'hFFFF, 0, 1, 8'h00, 0, 0, 0);
    tbl[15] = mk(0, 0, 16'hFFFF, 0, 1, 8'h02, 0, 0, 0);
    tbl[16] = mk(0, 0, 16'hFFFF, 0, 1, 8'h00, 0, 0, 0);
    tbl[17] = mk(0, 0, 16'hFFFF, 0, 1, 8'h03, 0, 1, 0);
    tbl[18] = mk(0, 0, 16'hFFFF, 0, 0, 8'h03, 0, 1, 0);
    tbl[19] = mk(0, 0, 16'hFFFF, 0, 0, 8'h03, 0, 1, 0);

    rst = 1'b1; start = 1'b0; din = '0;
    cyc();
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; din = tbl[i].din;
      @(negedge clk);
      chk($sformatf("row%0d_wr", i), wr_en, tbl[i].wr);
      chk($sformatf("row%0d_eth", i), eth_en, tbl[i].eth);
      chk($sformatf("row%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("row%0d_full", i), full, tbl[i].full);
      chk($sformatf("row%0d_empty", i), empty, tbl[i].empty);
      chk($sformatf("row%0d_busy", i), rst_busy, tbl[i].busy);
      cyc();
    end

    // Continuous ramp with start held: refill carries current din.
    start = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      din = 16'h0010 + 16'(k);
      @(negedge clk);
      if (wr_en) n++;
      cyc();
    end
    chk("ramp_two_frames", (n >= 2 * DW), 1);
    start = 1'b0;
    for (int k = 0; k < 30; k++) cyc();

    // start dropped after two words: frame still completes.
    start = 1'b1;
    n = 0;
    for (int k = 0; k < 50 && n < 2; k++) begin
      din = 16'(($urandom));
      @(negedge clk);
      if (wr_en) n++;
      cyc();
    end
    chk("drop_first_two", n, 2);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      din = 16'($urandom);
      @(negedge clk);
      if (wr_en) n++;
      cyc();
    end
    chk("drop_remaining", n, DW - 2);

    // Reset pulse mid-drain, start kept high through rst_busy.
    start = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      din = 16'($urandom);
      @(negedge clk);
      if (eth_en) n++;
      cyc();
    end
    chk("drain_three", n, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      din = 16'($urandom);
      @(negedge clk);
      if (eth_en) n++;
      cyc();
    end
    chk("clean_frame_after_rst", (n >= FB), 1);
    start = 1'b0;
    for (int k = 0; k < 30; k++) cyc();

    // Random run against the scoreboard.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) start = ~start;
      rst = ($urandom_range(0, 249) == 0);
      din = 16'($urandom);
      cyc();
    end
    rst = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 40; k++) cyc();
    @(negedge clk);
    chk("final_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
